conv3x3_window_feeder: RTL and testbench



---
 rtl/conv3x3_window_feeder.sv | 229 ++++++++++++++++++++++
 tb/tb_conv3x3_window_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_window_feeder.sv
// 3x3 window feeder: walks the image, weights each fetched pixel and streams three columns per window.
// Optional `define CONV_ZERO_PAD_EN selects "same" convolution with 1-pixel zero padding.
module conv3x3_window_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int FRAC  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          w_we,
  input  logic [3:0]    w_idx,
  input  logic [DW-1:0] w_data,
  output logic [2:0]    rd_en,
  output logic [AW-1:0] rd_addr1,
  output logic [AW-1:0] rd_addr2,
  output logic [AW-1:0] rd_addr3,
  input  logic [DW-1:0] rd_data1,
  input  logic [DW-1:0] rd_data2,
  input  logic [DW-1:0] rd_data3,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2,
  output logic [DW-1:0] dout3,
  output logic [1:0]    addr,
  output logic          enable,
  output logic          endSign,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H) + 2;
`ifdef CONV_ZERO_PAD_EN
  localparam int X_MIN = -1;
  localparam int X_MAX = IMG_W - 2;
  localparam int Y_MIN = -1;
  localparam int Y_MAX = IMG_H - 2;
`else
  localparam int X_MIN = 0;
  localparam int X_MAX = IMG_W - 3;
  localparam int Y_MIN = 0;
  localparam int Y_MAX = IMG_H - 3;
`endif
  localparam logic signed [CW-1:0] X_MIN_C = CW'(X_MIN);
  localparam logic signed [CW-1:0] X_MAX_C = CW'(X_MAX);
  localparam logic signed [CW-1:0] Y_MIN_C = CW'(Y_MIN);
  localparam logic signed [CW-1:0] Y_MAX_C = CW'(Y_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nx;
  logic                  drain_cnt;
  logic                  issue;
  logic signed [CW-1:0]  x, y;
  logic [1:0]            k;
  logic                  last_win;
  logic                  issue_last;
  logic [DW-1:0]         w [3][3];
  logic [AW-1:0]         addr_a [3];
  logic [DW-1:0]         rd_data_a [3];
  logic [DW-1:0]         prod [3];
  logic                  s1_valid;
  logic [1:0]            s1_k;
  logic                  s1_last;
`ifdef CONV_ZERO_PAD_EN
  logic [2:0]            s1_mask;
`endif
  int                    row, col;

  function automatic logic [DW-1:0] mul(input logic signed [DW-1:0] a,
                                        input logic signed [DW-1:0] b);
    return DW'(((2*DW)'(a) * (2*DW)'(b)) >>> FRAC);
  endfunction

  assign last_win   = (x == X_MAX_C) && (y == Y_MAX_C);
  assign issue_last = issue && (k == 2'd2) && last_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (issue_last) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state)
      RUN:     begin busy = 1'b1; issue = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              drain_cnt <= 1'b0;
    else if (state == DRAIN) drain_cnt <= ~drain_cnt;
    else                     drain_cnt <= 1'b0;
  end

  // Counters are preloaded while idle so the first issued column is (X_MIN, Y_MIN, 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
      x <= '0;
      y <= '0;
    end else if (state == IDLE) begin
      k <= '0;
      x <= X_MIN_C;
      y <= Y_MIN_C;
    end else if (issue) begin
      if (k == 2'd2) begin
        k <= '0;
        if (x == X_MAX_C) begin
          x <= X_MIN_C;
          y <= y + CW'(1);
        end else begin
          x <= x + CW'(1);
        end
      end else begin
        k <= k + 2'd1;
      end
    end
  end

  always_comb begin
    rd_en = '0;
    row   = 0;
    col   = 0;
    for (int unsigned r = 0; r < 3; r++) begin
      row       = int'(y) + int'(r);
      col       = int'(x) + int'(k);
      addr_a[r] = '0;
`ifdef CONV_ZERO_PAD_EN
      if (issue && row >= 0 && row < IMG_H && col >= 0 && col < IMG_W) begin
`else
      if (issue) begin
`endif
        rd_en[r]  = 1'b1;
        addr_a[r] = AW'(row * IMG_W + col);
      end
    end
  end

  assign rd_addr1 = addr_a[0];
  assign rd_addr2 = addr_a[1];
  assign rd_addr3 = addr_a[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          w[r][c] <= '0;
    end else if (w_we && state == IDLE) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          if (w_idx == 4'(r * 3 + c)) w[r][c] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      s1_last  <= 1'b0;
`ifdef CONV_ZERO_PAD_EN
      s1_mask  <= '0;
`endif
    end else begin
      s1_valid <= issue;
      s1_k     <= k;
      s1_last  <= last_win;
`ifdef CONV_ZERO_PAD_EN
      s1_mask  <= rd_en;
`endif
    end
  end

  assign rd_data_a[0] = rd_data1;
  assign rd_data_a[1] = rd_data2;
  assign rd_data_a[2] = rd_data3;

  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      prod[r] = mul(rd_data_a[r], w[r][s1_k]);
`ifdef CONV_ZERO_PAD_EN
      if (!s1_mask[r]) prod[r] = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout1   <= '0;
      dout2   <= '0;
      dout3   <= '0;
      addr    <= '0;
      enable  <= 1'b0;
      endSign <= 1'b0;
    end else if (s1_valid) begin
      dout1   <= prod[0];
      dout2   <= prod[1];
      dout3   <= prod[2];
      addr    <= s1_k;
      enable  <= (s1_k == 2'd2);
      endSign <= (s1_k == 2'd2) && s1_last;
    end else begin
      dout1   <= '0;
      dout2   <= '0;
      dout3   <= '0;
      addr    <= '0;
      enable  <= 1'b0;
      endSign <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv3x3_window_feeder.sv
// Scoreboard bench for conv3x3_window_feeder on a 4x4 image (default "valid" build).
module tb_conv3x3_window_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        w_we = 1'b0;
  logic [3:0]  w_idx = '0;
  logic [15:0] w_data = '0;
  logic [2:0]  rd_en;
  logic [15:0] rd_addr1, rd_addr2, rd_addr3;
  logic [15:0] rd_data1, rd_data2, rd_data3;
  logic [15:0] dout1, dout2, dout3;
  logic [1:0]  addr;
  logic        enable, endSign, busy, done;

  conv3x3_window_feeder #(.IMG_W(4), .IMG_H(4), .DW(16), .AW(16), .FRAC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_we(w_we), .w_idx(w_idx), .w_data(w_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .dout1(dout1), .dout2(dout2), .dout3(dout3), .addr(addr), .enable(enable),
    .endSign(endSign), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16];

  always @(posedge clk) begin
    if (rd_en[0]) rd_data1 <= (rd_addr1 < 16'd16) ? mem[rd_addr1[3:0]] : 16'hDEAD;
    if (rd_en[1]) rd_data2 <= (rd_addr2 < 16'd16) ? mem[rd_addr2[3:0]] : 16'hDEAD;
    if (rd_en[2]) rd_data3 <= (rd_addr3 < 16'd16) ? mem[rd_addr3[3:0]] : 16'hDEAD;
  end

  typedef struct packed {
    logic [15:0] d1, d2, d3;
    logic [1:0]  a;
    logic        en, es;
    int          cyc;
  } col_t;

  col_t        exp_q[$];
  logic [15:0] sum_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [1:0]  pipe = '0;
  logic [15:0] acc = '0;

  // Window columns in stream order for pixel[i] = i with all weights 1.
  int tab1 [12][3] = '{'{0,4,8}, '{1,5,9}, '{2,6,10},
                       '{1,5,9}, '{2,6,10}, '{3,7,11},
                       '{4,8,12}, '{5,9,13}, '{6,10,14},
                       '{5,9,13}, '{6,10,14}, '{7,11,15}};
  int sums1 [4] = '{45, 54, 81, 90};
  int ctr   [4] = '{5, 6, 9, 10};
  int negv  [4] = '{16'hFFFE, 2, 8, 10};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    col_t        e;
    logic        v;
    logic [15:0] s;
    int          rel;
    v    = pipe[1] && rst_n;
    pipe <= rst_n ? {pipe[0], |rd_en} : 2'b00;
    rel  = cyc - t0 + 1;
    if (v) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_column: got d=%h/%h/%h addr=%0d en=%b, expected no column", dout1, dout2, dout3, addr, enable);
      end else begin
        e = exp_q.pop_front();
        if (dout1 !== e.d1 || dout2 !== e.d2 || dout3 !== e.d3 || addr !== e.a ||
            enable !== e.en || endSign !== e.es || rel != e.cyc) begin
          fails++;
          $display("FAIL column: got d=%h/%h/%h addr=%0d en=%b end=%b cyc=%0d, expected d=%h/%h/%h addr=%0d en=%b end=%b cyc=%0d",
                   dout1, dout2, dout3, addr, enable, endSign, rel, e.d1, e.d2, e.d3, e.a, e.en, e.es, e.cyc);
        end
      end
      s = ((addr == 2'd0) ? 16'd0 : acc) + dout1 + dout2 + dout3;
      acc <= s;
      if (enable) begin
        tests++;
        if (sum_q.size() == 0) begin
          fails++;
          $display("FAIL window_sum: got %h, expected no window", s);
        end else if (s !== sum_q[0]) begin
          fails++;
          $display("FAIL window_sum: got %h, expected %h", s, sum_q[0]);
        end
        if (sum_q.size() != 0) void'(sum_q.pop_front());
      end
    end else begin
      tests++;
      if (dout1 !== 16'd0 || dout2 !== 16'd0 || dout3 !== 16'd0 || addr !== 2'd0 ||
          enable !== 1'b0 || endSign !== 1'b0) begin
        fails++;
        $display("FAIL idle_outputs: got d=%h/%h/%h addr=%0d en=%b end=%b, expected all 0",
                 dout1, dout2, dout3, addr, enable, endSign);
      end
    end
  end

  task automatic wr_w(input int idx, input int val);
    @(negedge clk);
    w_we   = 1'b1;
    w_idx  = 4'(idx);
    w_data = 16'(val);
    @(negedge clk);
    w_we   = 1'b0;
  endtask

  task automatic set_all_w(input int val);
    for (int i = 0; i < 9; i++) wr_w(i, val);
  endtask

  // kind 0: all weights 1; kind 1: centre weight only; kind 2: w[0]=2 with pixel 0 = -1
  task automatic push(input int kind, input int ncols);
    col_t e;
    for (int n = 0; n < ncols; n++) begin
      int wn, kn;
      wn   = n / 3;
      kn   = n % 3;
      e    = '0;
      e.a  = 2'(kn);
      e.en = (kn == 2);
      e.es = (n == 11);
      e.cyc = 3 + n;
      case (kind)
        0: begin e.d1 = 16'(tab1[n][0]); e.d2 = 16'(tab1[n][1]); e.d3 = 16'(tab1[n][2]); end
        1: e.d2 = (kn == 1) ? 16'(ctr[wn]) : 16'd0;
        default: e.d1 = (kn == 0) ? 16'(negv[wn]) : 16'd0;
      endcase
      exp_q.push_back(e);
      if (kn == 2)
        sum_q.push_back(kind == 0 ? 16'(sums1[wn]) : kind == 1 ? 16'(ctr[wn]) : 16'(negv[wn]));
    end
  endtask

  task automatic launch(input bit wws, input logic [15:0] wval);
    @(negedge clk);
    start = 1'b1;
    if (wws) begin w_we = 1'b1; w_idx = 4'd0; w_data = wval; end
    @(posedge clk);
    #1;
    start = 1'b0;
    w_we  = 1'b0;
    t0    = cyc;
  endtask

  task automatic run_pass(input bit contend, input bit wws, input logic [15:0] wval);
    int done_cyc, busy_cnt;
    done_cyc = -1;
    busy_cnt = 0;
    launch(wws, wval);
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (contend && c == 6) begin start = 1'b1; w_we = 1'b1; w_idx = 4'd0; w_data = 16'd7; end
      if (contend && c == 7) begin start = 1'b0; w_we = 1'b0; end
      if (busy) busy_cnt++;
      if (done) done_cyc = c;
    end
    tests++;
    if (done_cyc != 15) begin
      fails++;
      $display("FAIL done_cycle: got %0d, expected 15", done_cyc);
    end
    tests++;
    if (busy_cnt != 14) begin
      fails++;
      $display("FAIL busy_cycles: got %0d, expected 14", busy_cnt);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || rd_en !== 3'b000) begin
      fails++;
      $display("FAIL no_restart: got busy=%b rd_en=%b, expected 0/000", busy, rd_en);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i);
    repeat (3) @(negedge clk);
    tests++;
    if (rd_en !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || dout1 !== 16'd0 || enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got rd_en=%b busy=%b done=%b dout1=%h en=%b, expected all 0",
               rd_en, busy, done, dout1, enable);
    end
    rst_n = 1'b1;

    set_all_w(1);
    push(0, 12);
    run_pass(1'b0, 1'b0, 16'd0);

    set_all_w(0);
    wr_w(4, 1);
    push(1, 12);
    run_pass(1'b0, 1'b0, 16'd0);

    // w[0] lands in the same cycle as start
    mem[0] = 16'hFFFF;
    set_all_w(0);
    push(2, 12);
    run_pass(1'b0, 1'b1, 16'd2);
    mem[0] = 16'd0;

    set_all_w(1);
    push(0, 12);
    run_pass(1'b1, 1'b0, 16'd0);
    push(0, 12);
    run_pass(1'b0, 1'b0, 16'd0);

    // reset during cycle 9: only the first two windows reach the output
    push(0, 6);
    launch(1'b0, 16'd0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (dout1 !== 16'd0 || dout2 !== 16'd0 || dout3 !== 16'd0 || addr !== 2'd0 || enable !== 1'b0 ||
        endSign !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 3'b000) begin
      fails++;
      $display("FAIL reset_midpass: got d=%h/%h/%h addr=%0d en=%b busy=%b rd_en=%b, expected all 0",
               dout1, dout2, dout3, addr, enable, busy, rd_en);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_all_w(1);
    push(0, 12);
    run_pass(1'b0, 1'b0, 16'd0);

    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() != 0 || sum_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expected: got %0d columns/%0d sums pending, expected 0/0", exp_q.size(), sum_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
